aes_decrypt_seq: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 InvCipher), the receive-side counterpart of the AES encrypt path in the AES/UART design. It takes a 128-bit ciphertext block from the UART receive assembly and returns the 128-bit plaintext under the same fixed 128-bit key the encrypt side uses. One round is computed per clock. Round keys are expanded on chip and held in a register file.

---
 rtl/aes_decrypt_seq.sv | 206 ++++++++++++++++++++
 tb/tb_aes_decrypt_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_seq.sv
// AES-128 inverse cipher, one round per clock; `AES_DEC_KEYCACHE_EN keeps expanded round keys across blocks.
// Latency: flag in the cycle after edge T+21 (T+11 when cached keys are reused); result held until next flag.
// No backpressure: start is sampled only in IDLE, never queued; flag is a single-cycle pulse.
module aes_decrypt_seq #(
  parameter logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  output logic [127:0] decrypted128,
  output logic         busy,
  output logic         flag
);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [127:0] st;
  logic [127:0] kw;
  logic [127:0] kexp;
  logic [127:0] rk [0:10];
  logic [127:0] rk_sel;
  logic [127:0] sb_out, ark, imc, round_out;
  logic [31:0]  kt;
  logic         accept, done, cache_hit;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b;
    b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    case (k)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // kw always holds the most recently expanded round key
  assign kt = {sbox(kw[23:16]), sbox(kw[15:8]), sbox(kw[7:0]), sbox(kw[31:24])} ^ {rcon(cnt), 24'h0};
  assign kexp[127:96] = kw[127:96] ^ kt;
  assign kexp[95:64]  = kw[95:64]  ^ kexp[127:96];
  assign kexp[63:32]  = kw[63:32]  ^ kexp[95:64];
  assign kexp[31:0]   = kw[31:0]   ^ kexp[63:32];

  assign rk_sel = rk[cnt];

  // InvShiftRows folded into the byte selection feeding the inverse S-boxes
  always_comb begin
    sb_out = '0;
    imc    = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb_out[127-8*(r+4*c) -: 8] = inv_sbox(st[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    ark = sb_out ^ rk_sel;
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end
    if (cnt == 4'd10)     round_out = st ^ rk_sel;
    else if (cnt == 4'd0) round_out = ark;
    else                  round_out = imc;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = cache_hit ? ROUND : KEYEXP;
        end
      end
      KEYEXP: begin
        if (cnt == 4'd10) state_nxt = ROUND;
      end
      ROUND: begin
        if (cnt == 4'd0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      st           <= '0;
      flag         <= 1'b0;
      decrypted128 <= '0;
    end else begin
      state <= state_nxt;
      flag  <= done;
      if (accept) begin
        st  <= in;
        cnt <= cache_hit ? 4'd10 : 4'd1;
      end else if (state == KEYEXP) begin
        if (cnt != 4'd10) cnt <= cnt + 4'd1;
      end else if (state == ROUND) begin
        st <= round_out;
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end
      if (done) decrypted128 <= round_out;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      kw    <= KEY;
      rk[0] <= KEY;
    end else if (state == KEYEXP) begin
      kw      <= kexp;
      rk[cnt] <= kexp;
    end
  end

`ifdef AES_DEC_KEYCACHE_EN
  logic key_vld;

  always_ff @(posedge clk) begin
    if (rst)                                  key_vld <= 1'b0;
    else if (state == KEYEXP && cnt == 4'd10) key_vld <= 1'b1;
  end

  assign cache_hit = key_vld;
`else
  assign cache_hit = 1'b0;
`endif

endmodule

// File: tb/tb_aes_decrypt_seq.sv
// Directed bench for aes_decrypt_seq: FIPS-197 C.1 plus ciphertexts built by a forward AES model,
// checked by a scoreboard monitor (plaintext, latency, busy window).
module tb_aes_decrypt_seq;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] in;
  logic [127:0] decrypted128;
  logic         busy;
  logic         flag;

  aes_decrypt_seq dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in(in),
    .decrypted128(decrypted128),
    .busy(busy),
    .flag(flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] pt;
    int           acc;
    int           done;
  } exp_t;

  exp_t       sb[$];
  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_fail = 0;
  bit         cached = 1'b0;
  logic [7:0] sbox_t [256];
  exp_t       e;
  logic       eb;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward cipher, used to manufacture ciphertexts whose plaintext is known
  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3, rc;
    logic [31:0]  tmp;
    logic [127:0] x, k;
    k  = KEY;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    x = pt ^ {w[0], w[1], w[2], w[3]};
    for (int rd = 1; rd <= 10; rd++) begin
      for (int b = 0; b < 16; b++) s[b] = sbox_t[x[127-8*b -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rd != 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int b = 0; b < 16; b++) x[127-8*b -: 8] = s[b];
      x = x ^ {w[4*rd], w[4*rd+1], w[4*rd+2], w[4*rd+3]};
    end
    return x;
  endfunction

  // Scoreboard monitor: samples 1 time unit after every rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    eb = 1'b0;
    if (sb.size() > 0) eb = (cyc >= sb[0].acc) && (cyc < sb[0].done);
    chk1("busy", busy, eb);
    if (flag === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_flag: flag=1 at cycle %0d, expected 0", cyc);
      end else begin
        e = sb.pop_front();
        chk("plaintext", decrypted128, e.pt);
        chk_int("latency", cyc - e.acc, e.done - e.acc);
      end
    end else if (sb.size() > 0) begin
      if (cyc >= sb[0].done) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_flag: flag=0 at cycle %0d, expected 1", cyc);
        e = sb.pop_front();
      end
    end
  end

  // Call at a falling edge with the DUT idle at the next rising edge
  task automatic issue(input logic [127:0] ct, input logic [127:0] pt, input bit stuck);
    exp_t x;
    int   lat;
    lat = cached ? 11 : 21;
`ifdef AES_DEC_KEYCACHE_EN
    cached = 1'b1;
`endif
    x.pt   = pt;
    x.acc  = cyc + 1;
    x.done = x.acc + lat;
    sb.push_back(x);
    start = 1'b1;
    in    = ct;
    @(negedge clk);
    if (stuck) begin
      for (int i = 0; i < lat - 1; i++) begin
        in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic wait_flag();
    int n;
    n = 0;
    while (flag !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (flag !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL flag_timeout: no flag within 40 cycles at cycle %0d, expected one", cyc);
    end
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    start = 1'b0;
    sb.delete();
    cached = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   v, bb, xb, c63;
    logic [127:0] pt;
    rst   = 1'b1;
    start = 1'b0;
    in    = '0;
    c63   = 8'h63;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      v  = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(xb, 8'(y)) == 8'h01) v = 8'(y);
      for (int i = 0; i < 8; i++)
        bb[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c63[i];
      sbox_t[x] = bb;
    end

    apply_reset();
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_flag", flag, 1'b0);
    chk("reset_out", decrypted128, 128'h0);

    // FIPS-197 C.1
    issue(CT1, PT1, 1'b0);
    wait_flag();

    // Back-to-back blocks, each start issued in the previous flag cycle
    for (int i = 0; i < 8; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      issue(aes_enc(pt), pt, 1'b0);
      wait_flag();
    end

    // start held and in toggled while busy
    pt = {$urandom, $urandom, $urandom, $urandom};
    issue(aes_enc(pt), pt, 1'b1);
    wait_flag();

    // Reset at edge T+12 aborts the block
    apply_reset();
    issue(CT1, PT1, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    cached = 1'b0;
    @(negedge clk);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_flag", flag, 1'b0);
    chk("abort_out", decrypted128, 128'h0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    issue(CT1, PT1, 1'b0);
    wait_flag();

    // Second block (reuses keys when caching is built in), then reset forces full expansion
    issue(CT1, PT1, 1'b0);
    wait_flag();
    apply_reset();
    issue(CT1, PT1, 1'b0);
    wait_flag();

    // Output hold with start low
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      chk("hold_out", decrypted128, PT1);
      @(negedge clk);
    end
    chk_int("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
